// File: rtl/scratch_pad.sv
// ---------------------------------------------------------------------------
// scratch_pad
//   Multi-port banked scratch memory. Every request port has its own request
//   FIFO. The FIFO heads compete for low-order interleaved single-port banks,
//   and each bank has its own round-robin arbiter. Reads return on a fixed
//   three-stage pipeline, so each port sees its completions in request order.
//
//   Optional build macro: SCRATCH_PAD_DEBUG_EN prints accepted requests and
//   read completions. It adds no synthesized logic.
//
// Ports
//   rst    in   async active-low reset
//   clk    in   clock, rising edge
//   rd_en  in   [0:PORTS-1] read request per port
//   wr_en  in   [0:PORTS-1] write request per port (wins over rd_en)
//   d      in   write data, port i at [(PORTS-i)*WIDTH-1 -: WIDTH]
//   q      out  read data, same slicing as d, holds when valid is low
//   addr   in   word address, port i at [(PORTS-i)*ADDR_WIDTH-1 -: ADDR_WIDTH]
//   stall  in   [0:PORTS-1] block grants to that port's FIFO head
//   valid  out  [0:PORTS-1] one-cycle qualifier for the q slice of the port
//   full   out  [0:PORTS-1] request FIFO cannot accept
// ---------------------------------------------------------------------------
module scratch_pad #(
  parameter  int PORTS          = 8,
  parameter  int WIDTH          = 32,
  parameter  int FRAGMENT_DEPTH = 512,
  parameter  int REORDER_DEPTH  = 32,
  localparam int ADDR_WIDTH     = $clog2(PORTS * FRAGMENT_DEPTH)
) (
  input  logic                        rst,
  input  logic                        clk,
  input  logic [0:PORTS-1]            rd_en,
  input  logic [0:PORTS-1]            wr_en,
  input  logic [PORTS*WIDTH-1:0]      d,
  output logic [PORTS*WIDTH-1:0]      q,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [0:PORTS-1]            stall,
  output logic [0:PORTS-1]            valid,
  output logic [0:PORTS-1]            full
);

  localparam int BW = $clog2(PORTS);
  localparam int RW = ADDR_WIDTH - BW;
  localparam int PW = $clog2(REORDER_DEPTH);
  localparam int CW = $clog2(REORDER_DEPTH + 1);

  typedef logic [BW-1:0] port_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(REORDER_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Per-port views of the flattened buses
  logic [WIDTH-1:0]      d_s    [PORTS];
  logic [ADDR_WIDTH-1:0] addr_s [PORTS];
  logic [WIDTH-1:0]      q_q    [PORTS];
  logic [0:PORTS-1]      valid_q;

  for (genvar p = 0; p < PORTS; p++) begin : g_slice
    assign d_s[p]    = d[(PORTS-p)*WIDTH-1 -: WIDTH];
    assign addr_s[p] = addr[(PORTS-p)*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign q[(PORTS-p)*WIDTH-1 -: WIDTH] = q_q[p];
  end

  assign valid = valid_q;

  // Request FIFOs
  logic                  fifo_wr_q   [PORTS][REORDER_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [PORTS][REORDER_DEPTH];
  logic [WIDTH-1:0]      fifo_data_q [PORTS][REORDER_DEPTH];
  logic [PW-1:0]         wr_ptr_q [PORTS], wr_ptr_d [PORTS];
  logic [PW-1:0]         rd_ptr_q [PORTS], rd_ptr_d [PORTS];
  logic [CW-1:0]         cnt_q    [PORTS], cnt_d    [PORTS];
  logic [PORTS-1:0]      enq, deq, req_vld;
  logic                  head_wr   [PORTS];
  logic [ADDR_WIDTH-1:0] head_addr [PORTS];
  logic [WIDTH-1:0]      head_data [PORTS];

  // Arbitration and pipeline state (indexed by bank)
  logic          bank_gnt  [PORTS];
  port_t         bank_sel  [PORTS];
  port_t         rr_q      [PORTS], rr_d [PORTS];
  logic          s1_vld_q  [PORTS];
  logic          s1_wr_q   [PORTS];
  port_t         s1_port_q [PORTS];
  logic [RW-1:0] s1_row_q  [PORTS];
  logic [WIDTH-1:0] s1_data_q [PORTS];
  logic          rd_vld_q  [PORTS];
  port_t         rd_port_q [PORTS];
  logic [WIDTH-1:0] rdata  [PORTS];
  logic          out_vld   [PORTS];
  logic [WIDTH-1:0] out_data [PORTS];

  // full comes from the registered count only, so a dequeue in the same
  // cycle never frees a slot for the incoming request.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      full[p]      = (cnt_q[p] == CW'(REORDER_DEPTH));
      enq[p]       = (rd_en[p] | wr_en[p]) & ~full[p];
      req_vld[p]   = (cnt_q[p] != '0) & ~stall[p];
      head_wr[p]   = fifo_wr_q[p][rd_ptr_q[p]];
      head_addr[p] = fifo_addr_q[p][rd_ptr_q[p]];
      head_data[p] = fifo_data_q[p][rd_ptr_q[p]];
    end
  end

  // Per-bank round robin: scan from the pointer, take the first head aimed
  // at this bank, then move the pointer just past the winner.
  always_comb begin
    deq = '0;
    for (int b = 0; b < PORTS; b++) begin
      bank_gnt[b] = 1'b0;
      bank_sel[b] = '0;
      rr_d[b]     = rr_q[b];
      for (int k = 0; k < PORTS; k++) begin
        port_t cand;
        cand = rr_q[b] + port_t'(k);
        if (!bank_gnt[b] && req_vld[cand] && (head_addr[cand][BW-1:0] == port_t'(b))) begin
          bank_gnt[b] = 1'b1;
          bank_sel[b] = cand;
          rr_d[b]     = cand + 1'b1;
        end
      end
      if (bank_gnt[b]) deq[bank_sel[b]] = 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      wr_ptr_d[p] = enq[p] ? ptr_inc(wr_ptr_q[p]) : wr_ptr_q[p];
      rd_ptr_d[p] = deq[p] ? ptr_inc(rd_ptr_q[p]) : rd_ptr_q[p];
      cnt_d[p]    = cnt_q[p];
      if (enq[p] && !deq[p])      cnt_d[p] = cnt_q[p] + 1'b1;
      else if (!enq[p] && deq[p]) cnt_d[p] = cnt_q[p] - 1'b1;
    end
  end

  // At most one bank returns data to a given port per cycle, because a port
  // has only one head and so gets at most one grant per cycle.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      out_vld[p]  = 1'b0;
      out_data[p] = q_q[p];
      for (int b = 0; b < PORTS; b++) begin
        if (rd_vld_q[b] && (rd_port_q[b] == port_t'(p))) begin
          out_vld[p]  = 1'b1;
          out_data[p] = rdata[b];
        end
      end
    end
  end

  // FIFO storage, not reset. Both enables high stores a write.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (enq[p]) begin
        fifo_wr_q[p][wr_ptr_q[p]]   <= wr_en[p];
        fifo_addr_q[p][wr_ptr_q[p]] <= addr_s[p];
        fifo_data_q[p][wr_ptr_q[p]] <= d_s[p];
      end
    end
  end

  // Banks, not reset. A read returns on the next edge.
  for (genvar b = 0; b < PORTS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [FRAGMENT_DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (s1_vld_q[b]) begin
        if (s1_wr_q[b]) mem[s1_row_q[b]] <= s1_data_q[b];
        else            rdata_q <= mem[s1_row_q[b]];
      end
    end

    assign rdata[b] = rdata_q;
  end

  // Control state. Reset clears every queue and every in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PORTS; i++) begin
        wr_ptr_q[i]  <= '0;
        rd_ptr_q[i]  <= '0;
        cnt_q[i]     <= '0;
        rr_q[i]      <= '0;
        s1_vld_q[i]  <= 1'b0;
        s1_wr_q[i]   <= 1'b0;
        s1_port_q[i] <= '0;
        s1_row_q[i]  <= '0;
        s1_data_q[i] <= '0;
        rd_vld_q[i]  <= 1'b0;
        rd_port_q[i] <= '0;
        valid_q[i]   <= 1'b0;
        q_q[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        wr_ptr_q[i]  <= wr_ptr_d[i];
        rd_ptr_q[i]  <= rd_ptr_d[i];
        cnt_q[i]     <= cnt_d[i];
        rr_q[i]      <= rr_d[i];
        s1_vld_q[i]  <= bank_gnt[i];
        s1_wr_q[i]   <= head_wr[bank_sel[i]];
        s1_port_q[i] <= bank_sel[i];
        s1_row_q[i]  <= head_addr[bank_sel[i]][ADDR_WIDTH-1:BW];
        s1_data_q[i] <= head_data[bank_sel[i]];
        rd_vld_q[i]  <= s1_vld_q[i] & ~s1_wr_q[i];
        rd_port_q[i] <= s1_port_q[i];
        valid_q[i]   <= out_vld[i];
        q_q[i]       <= out_data[i];
      end
    end
  end

`ifdef SCRATCH_PAD_DEBUG_EN
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (rst && enq[p])
        $display("scratch_pad %0t: accept port %0d %s addr=0x%0h data=0x%0h",
                 $time, p, wr_en[p] ? "WR" : "RD", addr_s[p], d_s[p]);
      if (rst && valid_q[p])
        $display("scratch_pad %0t: complete port %0d q=0x%0h", $time, p, q_q[p]);
    end
  end
`endif

endmodule

// File: tb/tb_scratch_pad.sv
module tb_scratch_pad;
  localparam int P  = 8;
  localparam int W  = 32;
  localparam int AW = 12;

  logic           rst, clk;
  logic [0:P-1]   rd_en, wr_en, stall, valid, full;
  logic [P*W-1:0] d, q;
  logic [P*AW-1:0] addr;

  scratch_pad #(.PORTS(P), .WIDTH(W), .FRAGMENT_DEPTH(512), .REORDER_DEPTH(32)) dut (
    .rst(rst), .clk(clk), .rd_en(rd_en), .wr_en(wr_en), .d(d), .q(q),
    .addr(addr), .stall(stall), .valid(valid), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [W-1:0] ref_mem [4096];
  logic [W-1:0] exp_q [P][$];
  int comp_cnt [P];
  int all_cycles = 0, max_vpc = 0;
  bit full_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < P; p++) s += exp_q[p].size();
    return s;
  endfunction

  function automatic int total_comp();
    int s = 0;
    for (int p = 0; p < P; p++) s += comp_cnt[p];
    return s;
  endfunction

  // Advance one cycle; sample outputs at the falling edge and score them.
  task automatic step();
    int nv;
    logic [W-1:0] e;
    @(negedge clk);
    if (rst) begin
      nv = 0;
      if (full != '0) full_seen = 1'b1;
      for (int p = 0; p < P; p++) begin
        if (valid[p]) begin
          nv++;
          comp_cnt[p]++;
          check($sformatf("sb_nonempty_p%0d", p), exp_q[p].size() != 0, 1);
          if (exp_q[p].size() != 0) begin
            e = exp_q[p].pop_front();
            check($sformatf("rd_data_p%0d", p), q[(P-p)*W-1 -: W], e);
          end
        end
      end
      if (nv == P) all_cycles++;
      if (nv > max_vpc) max_vpc = nv;
    end
  endtask

  task automatic clear_inputs();
    rd_en = '0; wr_en = '0; d = '0; addr = '0;
  endtask

  task automatic issue(input int p, input bit wr, input int a, input logic [W-1:0] data,
                       output bit acc);
    acc = 1'b0;
    if (!full[p]) begin
      acc = 1'b1;
      addr[(P-p)*AW-1 -: AW] = AW'(a);
      d[(P-p)*W-1 -: W] = data;
      if (wr) begin
        wr_en[p] = 1'b1;
        ref_mem[a] = data;
      end else begin
        rd_en[p] = 1'b1;
        exp_q[p].push_back(ref_mem[a]);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (pending() != 0 && t < 3000) begin
      step();
      t++;
    end
    check("drain_empty", pending(), 0);
    repeat (4) step();
  endtask

  initial begin
    bit acc;
    int a, s0, mn, mx;
    int snap [P];
    int j [P];
    for (int p = 0; p < P; p++) comp_cnt[p] = 0;

    // Reset state
    rst = 1'b0; stall = '0; clear_inputs();
    repeat (3) step();
    check("rst_valid", valid, 0);
    check("rst_full", full, 0);
    check("rst_q", q, 0);
    rst = 1'b1;
    step();

    // Write 42, read back after ten idle cycles, exact latency of 3
    clear_inputs(); issue(0, 1, 0, 42, acc); step();
    clear_inputs(); repeat (10) step();
    issue(0, 0, 0, 0, acc); step();
    clear_inputs();
    step(); check("lat_edge1", valid, 0);
    step(); check("lat_edge2", valid, 0);
    step(); check("lat_edge3", valid, 8'h80);
    check("q0_is_42", q[P*W-1 -: W], 42);
    step(); check("valid_one_cycle", valid, 0);
    check("q0_hold", q[P*W-1 -: W], 42);

    // Overwrite with 0 and read back
    issue(0, 1, 0, 0, acc); step();
    clear_inputs(); issue(0, 0, 0, 0, acc); step();
    clear_inputs(); repeat (3) step();
    check("q0_is_0", q[P*W-1 -: W], 0);

    // Port 0 fills 0..1023 with random data, then reads it all back
    a = 0;
    for (int t = 0; t < 5000 && a < 1024; t++) begin
      clear_inputs(); issue(0, 1, a, $urandom, acc);
      if (acc) a++;
      step();
    end
    check("wr_sweep_issued", a, 1024);
    s0 = comp_cnt[0]; a = 0;
    for (int t = 0; t < 5000 && a < 1024; t++) begin
      clear_inputs(); issue(0, 0, a, 0, acc);
      if (acc) a++;
      step();
    end
    clear_inputs(); drain();
    check("rd_sweep_count", comp_cnt[0] - s0, 1024);

    // All ports, distinct banks: full throughput, no backpressure
    full_seen = 1'b0; s0 = all_cycles;
    for (int p = 0; p < P; p++) snap[p] = comp_cnt[p];
    for (int c = 0; c < 1000; c++) begin
      clear_inputs();
      for (int p = 0; p < P; p++) issue(p, 0, p, 0, acc);
      step();
    end
    clear_inputs(); drain();
    check("distinct_full_seen", full_seen, 0);
    check("distinct_all_valid_cycles", all_cycles - s0, 1000);
    for (int p = 0; p < P; p++)
      check($sformatf("distinct_count_p%0d", p), comp_cnt[p] - snap[p], 1000);

    // All ports into bank 0: one completion per cycle, fair share
    full_seen = 1'b0; max_vpc = 0;
    for (int p = 0; p < P; p++) j[p] = 0;
    for (int c = 0; c < 200; c++) begin
      clear_inputs();
      if (c == 120) for (int p = 0; p < P; p++) snap[p] = comp_cnt[p];
      for (int p = 0; p < P; p++) begin
        issue(p, 0, (j[p] * 8) % 1024, 0, acc);
        if (acc) j[p]++;
      end
      step();
    end
    mn = 1 << 30; mx = 0; s0 = 0;
    for (int p = 0; p < P; p++) begin
      a = comp_cnt[p] - snap[p];
      s0 += a;
      if (a < mn) mn = a;
      if (a > mx) mx = a;
    end
    check("bank0_total_80", s0, 80);
    check("bank0_fair", (mx - mn) <= 1, 1);
    check("bank0_full_seen", full_seen, 1);
    check("bank0_max_per_cycle", max_vpc, 1);
    clear_inputs(); drain();

    // Stall on port 3: only the two already granted reads complete
    for (int k = 0; k < 4; k++) begin
      clear_inputs(); issue(3, 0, 3 + 8 * k, 0, acc);
      if (k == 3) begin
        stall[3] = 1'b1;
        s0 = comp_cnt[3];
      end
      step();
    end
    clear_inputs(); repeat (12) step();
    check("stall_pulses", comp_cnt[3] - s0, 2);
    stall[3] = 1'b0; drain();
    check("stall_released", comp_cnt[3] - s0, 4);

    // Random reads on all ports with stall pulsing on port 3
    s0 = total_comp(); a = 0;
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      stall[3] = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          issue(p, 0, $urandom_range(0, 1023), 0, acc);
          if (acc) a++;
        end
      end
      step();
    end
    stall = '0; clear_inputs(); drain();
    check("rand_count", total_comp() - s0, a);

    // Reset in the middle of traffic drops everything
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      for (int p = 0; p < P; p++) issue(p, 0, p * 8, 0, acc);
      step();
    end
    clear_inputs();
    rst = 1'b0;
    for (int p = 0; p < P; p++) exp_q[p].delete();
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_full", full, 0);
    check("midrst_q", q, 0);
    step(); step();
    rst = 1'b1;
    s0 = total_comp();
    repeat (10) step();
    check("midrst_no_pulses", total_comp() - s0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
